// File: rtl/conv_sched_pkg.sv
// Shared types and address helpers for the convolution filter scheduler.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam int KSIZE = 9;

  // Number of engine output pixels for an h x w input image.
  function automatic int out_pix(input int h, input int w);
    return (h - 2) * (w - 2);
  endfunction

  function automatic int filter_base(input int idx, input int h, input int w);
    return idx * out_pix(h, w);
  endfunction

endpackage

// File: rtl/conv_sched_if.sv
// Bus between the scheduler (master) and its control / weight memory / engine / feature-map side (slave).
interface conv_sched_if #(
  parameter int NUM_FILTERS = 4,
  parameter int WADDR_W     = 6,
  parameter int OUT_AW      = 12
);
  localparam int FIW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  logic                start;
  logic                abort;
  logic                busy;
  logic                all_done;
  logic                err;
  logic [FIW-1:0]      filter_idx;
  logic [WADDR_W-1:0]  w_addr;
  logic signed [7:0]   w_data;
  logic signed [7:0]   kernel0, kernel1, kernel2;
  logic signed [7:0]   kernel3, kernel4, kernel5;
  logic signed [7:0]   kernel6, kernel7, kernel8;
  logic                conv_en;
  logic                conv_store;
  logic [9:0]          conv_address;
  logic signed [7:0]   conv_result;
  logic                conv_done;
  logic                om_we;
  logic [OUT_AW-1:0]   om_addr;
  logic signed [7:0]   om_data;

  modport master (
    input  start, abort, w_data, conv_store, conv_address, conv_result, conv_done,
    output busy, all_done, err, filter_idx, w_addr,
           kernel0, kernel1, kernel2, kernel3, kernel4, kernel5, kernel6, kernel7, kernel8,
           conv_en, om_we, om_addr, om_data
  );

  modport slave (
    output start, abort, w_data, conv_store, conv_address, conv_result, conv_done,
    input  busy, all_done, err, filter_idx, w_addr,
           kernel0, kernel1, kernel2, kernel3, kernel4, kernel5, kernel6, kernel7, kernel8,
           conv_en, om_we, om_addr, om_data
  );

endinterface

// File: rtl/conv_sched_wfetch.sv
// Weight fetch: walks the 9 weights of one filter and captures them into the kernel registers.
module conv_sched_wfetch
  import conv_sched_pkg::*;
#(
  parameter int FIW     = 2,
  parameter int WADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en,
  input  logic [FIW-1:0]      filter_idx,
  input  logic signed [7:0]   w_data,
  output logic [WADDR_W-1:0]  w_addr,
  output logic signed [7:0]   kern [KSIZE],
  output logic                fetch_done
);

  logic [3:0] k;
  logic [3:0] k_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            k <= '0;
    else if (!fetch_en || k == 4'(KSIZE)) k <= '0;
    else                                 k <= k + 4'd1;
  end

  // Memory read has one cycle of latency, so step k lands weight k-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KSIZE; i++) kern[i] <= '0;
    end else if (fetch_en) begin
      for (int i = 0; i < KSIZE; i++)
        if (k == 4'(i + 1)) kern[i] <= w_data;
    end
  end

  // The final capture step issues no new read; hold the address on the last weight.
  assign k_rd       = (k == 4'(KSIZE)) ? 4'(KSIZE - 1) : k;
  assign w_addr     = WADDR_W'(int'(filter_idx) * KSIZE + int'(k_rd));
  assign fetch_done = fetch_en && (k == 4'(KSIZE));

endmodule

// File: rtl/conv_scheduler.sv
// Runs the 3x3 conv engine once per filter and remaps its store stream into the feature-map memory.
// state  | meaning
// IDLE   | waiting for start
// FETCH  | loading the current filter's 9 weights
// RUN    | engine enabled, stores remapped to feature-map memory
// FINISH | one-cycle all_done pulse after the last filter
module conv_scheduler
  import conv_sched_pkg::*;
#(
  parameter int H           = 28,
  parameter int W           = 28,
  parameter int NUM_FILTERS = 4,
  parameter int WADDR_W     = 6,
  parameter int OUT_AW      = 12
) (
  input  logic         clk,
  input  logic         rst,
  conv_sched_if.master bus
);

  localparam int FIW     = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int OUT_PIX = out_pix(H, W);
  localparam int LAST    = NUM_FILTERS - 1;

  state_t            state, state_nxt;
  logic [FIW-1:0]    filter_idx;
  logic              fetch_en, fetch_done;
  logic              run_live, store_ok;
  logic signed [7:0] kern [KSIZE];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.busy     = (state != S_IDLE);
    bus.all_done = (state == S_FINISH);
    bus.conv_en  = (state == S_RUN);
    if (bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (bus.start) state_nxt = S_FETCH;
        S_FETCH:  if (fetch_done) state_nxt = S_RUN;
        S_RUN:    if (bus.conv_done)
                    state_nxt = (filter_idx == FIW'(LAST)) ? S_FINISH : S_FETCH;
        S_FINISH: state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filter_idx <= '0;
    end else if (!bus.abort) begin
      if (state == S_IDLE && bus.start)
        filter_idx <= '0;
      else if (state == S_RUN && bus.conv_done && filter_idx != FIW'(LAST))
        filter_idx <= filter_idx + 1'b1;
    end
  end

  assign fetch_en = (state == S_FETCH) && !bus.abort;

  conv_sched_wfetch #(.FIW(FIW), .WADDR_W(WADDR_W)) u_wfetch (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .filter_idx (filter_idx),
    .w_data     (bus.w_data),
    .w_addr     (bus.w_addr),
    .kern       (kern),
    .fetch_done (fetch_done)
  );

  assign run_live = (state == S_RUN) && !bus.abort;
  assign store_ok = int'(bus.conv_address) < OUT_PIX;

  // Address uses the filter_idx of the store cycle, so a same-cycle conv_done cannot shift it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.om_we   <= 1'b0;
      bus.om_addr <= '0;
      bus.om_data <= '0;
      bus.err     <= 1'b0;
    end else begin
      bus.om_we <= run_live && bus.conv_store && store_ok;
      if (run_live && bus.conv_store && store_ok) begin
        bus.om_addr <= OUT_AW'(filter_base(int'(filter_idx), H, W) + int'(bus.conv_address));
        bus.om_data <= bus.conv_result;
      end
      if (state == S_IDLE && bus.start && !bus.abort)
        bus.err <= 1'b0;
      else if (run_live && bus.conv_store && !store_ok)
        bus.err <= 1'b1;
    end
  end

  assign bus.filter_idx = filter_idx;
  assign bus.kernel0 = kern[0];
  assign bus.kernel1 = kern[1];
  assign bus.kernel2 = kern[2];
  assign bus.kernel3 = kern[3];
  assign bus.kernel4 = kern[4];
  assign bus.kernel5 = kern[5];
  assign bus.kernel6 = kern[6];
  assign bus.kernel7 = kern[7];
  assign bus.kernel8 = kern[8];

endmodule

// File: tb/tb_conv_scheduler.sv
// Scoreboard bench for conv_scheduler on a 4x4 image with two filters.
module tb_conv_scheduler;

  localparam int H       = 4;
  localparam int W       = 4;
  localparam int NF      = 2;
  localparam int WADDR_W = 6;
  localparam int OUT_AW  = 12;
  localparam int OUT_PIX = (H - 2) * (W - 2);

  typedef struct {
    int addr;
    int data;
    int due;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  wr_t  exp_q [$];
  wr_t  mon_e;
  logic signed [7:0] wmem [NF*9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_sched_if #(.NUM_FILTERS(NF), .WADDR_W(WADDR_W), .OUT_AW(OUT_AW)) bus ();

  conv_scheduler #(
    .H(H), .W(W), .NUM_FILTERS(NF), .WADDR_W(WADDR_W), .OUT_AW(OUT_AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Weight memory with a registered read port.
  always @(posedge clk) begin
    if (int'(bus.w_addr) < NF*9) bus.w_data <= wmem[int'(bus.w_addr)];
    else                         bus.w_data <= 8'sh7f;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every feature-map write must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.om_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: om_addr=%0d om_data=%0d, no write expected",
                 bus.om_addr, bus.om_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("om_addr", int'(bus.om_addr), mon_e.addr);
        chk("om_data", int'(bus.om_data), mon_e.data);
        chk("om_latency_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_kern(input int base, input bit zero);
    logic signed [7:0] kv [9];
    kv[0] = bus.kernel0; kv[1] = bus.kernel1; kv[2] = bus.kernel2;
    kv[3] = bus.kernel3; kv[4] = bus.kernel4; kv[5] = bus.kernel5;
    kv[6] = bus.kernel6; kv[7] = bus.kernel7; kv[8] = bus.kernel8;
    for (int j = 0; j < 9; j++)
      chk($sformatf("kernel%0d", j), int'(kv[j]), zero ? 0 : int'(wmem[base + j]));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_all_done"}, int'(bus.all_done), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
    chk({tag, "_filter_idx"}, int'(bus.filter_idx), 0);
    chk({tag, "_w_addr"}, int'(bus.w_addr), 0);
    chk({tag, "_conv_en"}, int'(bus.conv_en), 0);
    chk({tag, "_om_we"}, int'(bus.om_we), 0);
    chk({tag, "_om_addr"}, int'(bus.om_addr), 0);
    chk({tag, "_om_data"}, int'(bus.om_data), 0);
    chk_kern(0, 1'b1);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Entered on the first FETCH cycle; leaves on the first RUN cycle.
  task automatic fetch_phase(input int f, input bit junk);
    for (int k = 0; k <= 9; k++) begin
      chk("fetch_conv_en", int'(bus.conv_en), 0);
      chk("fetch_busy", int'(bus.busy), 1);
      chk("fetch_filter_idx", int'(bus.filter_idx), f);
      if (k <= 8) chk($sformatf("w_addr_k%0d", k), int'(bus.w_addr), f*9 + k);
      if (junk) begin
        bus.conv_store   = 1'($urandom_range(0, 1));
        bus.conv_address = 10'($urandom_range(0, OUT_PIX - 1));
        bus.conv_result  = 8'($urandom);
        bus.conv_done    = 1'($urandom_range(0, 1));
        bus.start        = 1'($urandom_range(0, 1));
      end
      tick();
      bus.conv_store = 1'b0;
      bus.conv_done  = 1'b0;
      bus.start      = 1'b0;
    end
    chk("run_conv_en", int'(bus.conv_en), 1);
    chk_kern(f*9, 1'b0);
  endtask

  task automatic drive_store(input int f, input int addr, input logic signed [7:0] d);
    wr_t e;
    bus.conv_store   = 1'b1;
    bus.conv_address = 10'(addr);
    bus.conv_result  = d;
    if (addr < OUT_PIX) begin
      e.addr = f*OUT_PIX + addr;
      e.data = int'(d);
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic store(input int f, input int addr, input logic signed [7:0] d);
    drive_store(f, addr, d);
    tick();
    bus.conv_store = 1'b0;
  endtask

  task automatic done_cycle(input int f, input bit with_store, input int addr,
                            input logic signed [7:0] d);
    bus.conv_done = 1'b1;
    if (with_store) drive_store(f, addr, d);
    tick();
    bus.conv_done  = 1'b0;
    bus.conv_store = 1'b0;
    if (f < NF - 1) begin
      chk("next_conv_en", int'(bus.conv_en), 0);
      chk("next_filter_idx", int'(bus.filter_idx), f + 1);
      chk("next_all_done", int'(bus.all_done), 0);
      chk("next_busy", int'(bus.busy), 1);
      chk("kernel0_hold", int'(bus.kernel0), int'(wmem[f*9]));
    end else begin
      chk("all_done_pulse", int'(bus.all_done), 1);
      chk("finish_conv_en", int'(bus.conv_en), 0);
      chk("finish_busy", int'(bus.busy), 1);
      chk("finish_filter_idx", int'(bus.filter_idx), f);
      tick();
      chk("all_done_drop", int'(bus.all_done), 0);
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_filter_idx", int'(bus.filter_idx), f);
    end
  endtask

  task automatic random_run();
    bit bad_seen;
    int n, gap;
    bad_seen = 1'b0;
    for (int i = 0; i < NF*9; i++) wmem[i] = 8'($urandom);
    do_start();
    chk("start_clears_err", int'(bus.err), 0);
    for (int f = 0; f < NF; f++) begin
      fetch_phase(f, 1'b1);
      n = $urandom_range(0, 5);
      for (int s = 0; s < n; s++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          bus.start = 1'($urandom_range(0, 1));
          tick();
          bus.start = 1'b0;
          chk("run_hold_conv_en", int'(bus.conv_en), 1);
        end
        store(f, $urandom_range(0, OUT_PIX - 1), 8'($urandom));
        chk("run_store_conv_en", int'(bus.conv_en), 1);
      end
      if ($urandom_range(0, 3) == 0) begin
        store(f, OUT_PIX + $urandom_range(0, 200), 8'($urandom));
        bad_seen = 1'b1;
        chk("err_set", int'(bus.err), 1);
      end
      done_cycle(f, 1'($urandom_range(0, 1)), $urandom_range(0, OUT_PIX - 1), 8'($urandom));
    end
    chk("err_final", int'(bus.err), int'(bad_seen));
    tick();
    chk("sb_drain_random", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kk;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.conv_store = 1'b0; bus.conv_address = '0; bus.conv_result = '0; bus.conv_done = 1'b0;
    for (int i = 0; i < NF*9; i++) wmem[i] = 8'(i);

    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Identity weights: kernels 0..8 then 9..17, directed stores and edge cases.
    do_start();
    chk("start_err", int'(bus.err), 0);
    fetch_phase(0, 1'b0);
    done_cycle(0, 1'b0, 0, 8'sd0);
    fetch_phase(1, 1'b0);
    store(1, 3, -8'sd5);
    chk("dir_om_we", int'(bus.om_we), 1);
    chk("dir_om_addr", int'(bus.om_addr), 7);
    chk("dir_om_data", int'(bus.om_data), -5);
    store(1, OUT_PIX, 8'sd9);
    chk("bad_om_we", int'(bus.om_we), 0);
    chk("bad_err", int'(bus.err), 1);
    chk("bad_conv_en", int'(bus.conv_en), 1);
    done_cycle(1, 1'b1, 0, 8'sd12);
    chk("err_sticky_idle", int'(bus.err), 1);
    tick();
    chk("sb_drain_directed", exp_q.size(), 0);

    // Abort during FETCH.
    do_start();
    kk = $urandom_range(1, 8);
    repeat (kk) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_fetch_busy", int'(bus.busy), 0);
    chk("abort_fetch_conv_en", int'(bus.conv_en), 0);
    repeat (3) begin
      tick();
      chk("abort_fetch_all_done", int'(bus.all_done), 0);
      chk("abort_fetch_idle", int'(bus.busy), 0);
    end

    // Abort during RUN, with a store in the abort cycle that must be dropped.
    do_start();
    fetch_phase(0, 1'b0);
    store(0, 2, 8'sd33);
    store(0, OUT_PIX + 1, 8'sd1);
    chk("abort_run_err_set", int'(bus.err), 1);
    bus.abort = 1'b1;
    bus.conv_store = 1'b1; bus.conv_address = 10'd1; bus.conv_result = 8'sd77;
    tick();
    bus.abort = 1'b0; bus.conv_store = 1'b0;
    chk("abort_run_conv_en", int'(bus.conv_en), 0);
    chk("abort_run_busy", int'(bus.busy), 0);
    chk("abort_run_om_we", int'(bus.om_we), 0);
    chk("abort_run_err_kept", int'(bus.err), 1);
    chk_kern(0, 1'b0);
    repeat (3) begin
      tick();
      chk("abort_run_all_done", int'(bus.all_done), 0);
    end
    chk("sb_drain_abort", exp_q.size(), 0);

    repeat (6) random_run();

    // Asynchronous reset in the middle of RUN, then a clean run from scratch.
    for (int i = 0; i < NF*9; i++) wmem[i] = 8'($urandom);
    do_start();
    fetch_phase(0, 1'b0);
    store(0, OUT_PIX + 3, 8'sd1);
    store(0, 3, 8'sd55);
    #5;
    rst = 1'b0;
    #1;
    chk_reset("async_reset");
    @(negedge clk);
    rst = 1'b1;
    tick();
    do_start();
    fetch_phase(0, 1'b0);
    store(0, 1, -8'sd100);
    done_cycle(0, 1'b0, 0, 8'sd0);
    fetch_phase(1, 1'b0);
    done_cycle(1, 1'b1, 2, 8'sd64);
    tick();
    chk("sb_drain_final", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
